de0_nano_i2c_master_ctrl: RTL and testbench
===========================================

// Module: de0_nano_i2c_master_ctrl
// PURPOSE
//  Avalon-MM I2C master byte engine. Replaces CPU bit-banging of the SCL/SDA PIOs.
//  Sequences START, byte write with ACK capture, byte read with ACK/NACK, and STOP
//  on open-drain pads, with a programmable bit rate and slave clock-stretch support.
//  Sits on the Qsys bus beside the pad PIOs; the top level muxes pads to this block.
// PARAMETERS
//  DEFAULT_DIV  16'd124  reset value of DIV; quarter-bit period = DIV+1 clk (50MHz -> 100kHz)
// PORTS
//  clk         in   1   system clock
//  reset_n     in   1   asynchronous, active-low reset
//  address     in   2   register select: 0 DATA, 1 CMD, 2 STATUS, 3 DIV
//  chipselect  in   1   Avalon slave select
//  write_n     in   1   active-low write strobe
//  writedata   in   32  write data
//  readdata    out  32  read data, combinational from address; unused bits 0
//  scl_oe      out  1   1 = pull SCL low, 0 = release
//  sda_oe      out  1   1 = pull SDA low, 0 = release
//  scl_in      in   1   SCL pad level, synchronised internally (2 flops)
//  sda_in      in   1   SDA pad level, synchronised internally (2 flops)
//  irq         out  1   level, = STATUS.done & IEN
// BEHAVIOUR
//  Reset values: scl_oe=0, sda_oe=0, irq=0, busy=0, done=0, rx_nack=0, TX=RX=0,
//   DIV=DEFAULT_DIV, IEN=0, FSM=IDLE.
//  Registers:
//   DATA   W: TX[7:0]. R: RX[7:0].
//   CMD    W: [0]START [1]WRITE [2]READ [3]STOP [4]NACK (ACK bit sent after READ) [8]IEN.
//          Ignored (incl. IEN) while busy. Accepted write with any of [3:0] set:
//          busy=1, done=0 next clk. Order executed: START, WRITE or READ, STOP.
//          WRITE and READ both set: WRITE only. No op bit set: only IEN updated.
//   STATUS R: [0]busy [1]done (sticky) [2]rx_nack. done cleared by accepted CMD write.
//   DIV    W: [15:0], ignored while busy.
//  Timing: quarter tick every DIV+1 clk. Counter reloads on each phase entry.
//  FSM: IDLE -> START -> BIT(x9) -> STOP -> IDLE. Disabled phases are skipped.
//   Each phase has four quarters Q0..Q3.
//  START: Q0 sda_oe=0; Q1 scl_oe=0; Q2 sda_oe=1; Q3 scl_oe=1.
//   This also forms a repeated START when SCL is low on entry.
//  BIT n (n=7..0 data MSB first, then ACK slot):
//   Q0 scl_oe=1; sda_oe = ~bit (WRITE) or 0 (READ, or WRITE's ACK slot).
//      READ ACK slot: sda_oe = ~NACK.
//   Q1 scl_oe=0.  Q2 SCL high.  Q3 scl_oe=1.
//   Sample synchronised SDA at the last clk of Q2. READ data -> RX shift; WRITE ACK slot -> rx_nack.
//  STOP: Q0 scl_oe=1, sda_oe=1; Q1 scl_oe=0; Q2 sda_oe=0; Q3 idle, bus released.
//  Clock stretch: in any quarter following a scl_oe 1->0 release, the quarter counter
//   holds until synchronised scl_in==1. No timeout.
//  Completion: on the last clk of the final phase, busy=0 and done=1.
//   RX valid when done=1. Without STOP, scl_oe stays 1 (bus held) until the next CMD.
//  Latency: START/STOP = 4*(DIV+1) clk each; byte = 36*(DIV+1) clk, plus stretch time.
//  Async reset mid-transfer: pads released immediately. No STOP is generated.
//  DIV=0: quarter = 1 clk. Still legal.
// TESTING
//  1 Reset: readdata@STATUS=0, DIV=124, scl_oe=sda_oe=0.
//  2 DIV=3, TX=0xA5, CMD=0x0B, slave ACKs -> SDA pattern 10100101; rx_nack=0;
//    done=1 after 176 clk; bus released.
//  3 TX=0x3C, CMD=0x03, slave NACKs -> rx_nack=1, busy=0; SCL held low (scl_oe=1).
//  4 CMD=0x1C (READ|NACK|STOP), slave drives 0x96 -> RX=0x96; SDA released in ACK slot; STOP seen.
//  5 Slave holds SCL low 50 clk in bit 3 -> total time +50 clk, data intact.
//  6 CMD write while busy -> ignored. Reset asserted mid-byte -> pads released, STATUS=0.

Source files
------------

// File: rtl/de0_nano_i2c_master_ctrl.sv
// Avalon-MM I2C master byte engine: START, byte write/read with ACK, STOP on
// open-drain pads, programmable quarter-bit period and slave clock stretching.
module de0_nano_i2c_master_ctrl #(
    parameter logic [15:0] DEFAULT_DIV = 16'd124
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        scl_oe,
    output logic        sda_oe,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        irq
);

    typedef enum logic [1:0] {StIdle, StStart, StBit, StStop} phase_e;

    phase_e      r_phase;
    logic [1:0]  r_q;
    logic [15:0] r_cnt;
    logic [3:0]  r_bit;        // 0..7 data bits MSB first, 8 = ACK slot
    logic [7:0]  r_shift;
    logic [7:0]  r_tx;
    logic [7:0]  r_rx;
    logic [15:0] r_div;
    logic        r_ien;
    logic        r_busy;
    logic        r_done;
    logic        r_rx_nack;
    logic        r_op_wr;
    logic        r_op_rd;
    logic        r_op_stop;
    logic        r_op_nack;
    logic        r_scl_oe;
    logic        r_sda_oe;
    logic        r_scl_s1, r_scl_s2;
    logic        r_sda_s1, r_sda_s2;

    logic        w_wr;
    logic        w_cmd_wr;
    logic        w_go;
    logic        w_hold;
    logic        w_qend;
    logic        w_pend;
    logic        w_finish;
    logic        w_enter;
    logic        w_step;
    phase_e      w_first;
    phase_e      w_nxt_phase;
    logic [3:0]  w_nxt_bit;
    phase_e      w_ent_phase;
    logic [3:0]  w_ent_bit;
    logic [1:0]  w_ent_q;
    logic [7:0]  w_shift_nxt;
    logic        w_wr_n;
    logic        w_rd_n;
    logic        w_nack_n;
    logic        w_scl_nxt;
    logic        w_sda_nxt;
    logic        w_unused_wdata;

    assign w_unused_wdata = ^writedata[31:16];

    assign w_wr     = chipselect & ~write_n;
    assign w_cmd_wr = w_wr & (address == 2'd1) & ~r_busy;
    assign w_go     = w_cmd_wr & (|writedata[3:0]);
    // Q2 waits for SCL to actually go high after the Q1 release (clock stretch).
    assign w_hold   = (r_q == 2'd2) & ~r_scl_s2;
    assign w_qend   = r_busy & (r_cnt == 16'd0) & ~w_hold;
    assign w_pend   = w_qend & (r_q == 2'd3);
    assign w_finish = w_pend & (w_nxt_phase == StIdle);
    assign w_enter  = w_go | (w_pend & (w_nxt_phase != StIdle));
    assign w_step   = w_enter | (w_qend & ~w_pend);

    assign w_first  = writedata[0] ? StStart :
                      (writedata[1] | writedata[2]) ? StBit : StStop;

    assign w_ent_phase = w_go ? w_first : w_nxt_phase;
    assign w_ent_bit   = w_go ? 4'd0 : w_nxt_bit;
    assign w_ent_q     = w_enter ? 2'd0 : r_q + 2'd1;

    assign w_wr_n   = w_go ? writedata[1] : r_op_wr;
    assign w_rd_n   = w_go ? (writedata[2] & ~writedata[1]) : r_op_rd;
    assign w_nack_n = w_go ? writedata[4] : r_op_nack;

    assign scl_oe = r_scl_oe;
    assign sda_oe = r_sda_oe;
    assign irq    = r_done & r_ien;

    // Phase that follows the current one once its Q3 expires.
    always_comb begin
        w_nxt_phase = StIdle;
        w_nxt_bit   = 4'd0;
        case (r_phase)
            StStart: begin
                if (r_op_wr | r_op_rd) w_nxt_phase = StBit;
                else if (r_op_stop)    w_nxt_phase = StStop;
            end
            StBit: begin
                if (r_bit != 4'd8) begin
                    w_nxt_phase = StBit;
                    w_nxt_bit   = r_bit + 4'd1;
                end else if (r_op_stop) begin
                    w_nxt_phase = StStop;
                end
            end
            default: w_nxt_phase = StIdle;
        endcase
    end

    // Shift register advances after each data bit; loaded from TX on command accept.
    always_comb begin
        w_shift_nxt = r_shift;
        if (w_go)
            w_shift_nxt = r_tx;
        else if (w_pend && r_phase == StBit && r_bit != 4'd8)
            w_shift_nxt = {r_shift[6:0], 1'b0};
    end

    // Pad drive for the quarter being entered.
    always_comb begin
        w_scl_nxt = r_scl_oe;
        w_sda_nxt = r_sda_oe;
        case (w_enter ? w_ent_phase : r_phase)
            StStart: begin
                case (w_ent_q)
                    2'd0: w_sda_nxt = 1'b0;
                    2'd1: w_scl_nxt = 1'b0;
                    2'd2: w_sda_nxt = 1'b1;
                    default: w_scl_nxt = 1'b1;
                endcase
            end
            StBit: begin
                case (w_ent_q)
                    2'd0: begin
                        w_scl_nxt = 1'b1;
                        if (w_ent_bit == 4'd8) w_sda_nxt = w_rd_n & ~w_nack_n;
                        else                   w_sda_nxt = w_wr_n & ~w_shift_nxt[7];
                    end
                    2'd1: w_scl_nxt = 1'b0;
                    2'd2: w_scl_nxt = r_scl_oe;
                    default: w_scl_nxt = 1'b1;
                endcase
            end
            StStop: begin
                case (w_ent_q)
                    2'd0: begin
                        w_scl_nxt = 1'b1;
                        w_sda_nxt = 1'b1;
                    end
                    2'd1: w_scl_nxt = 1'b0;
                    2'd2: w_sda_nxt = 1'b0;
                    default: begin
                        w_scl_nxt = 1'b0;
                        w_sda_nxt = 1'b0;
                    end
                endcase
            end
            default: begin
                w_scl_nxt = r_scl_oe;
                w_sda_nxt = r_sda_oe;
            end
        endcase
    end

    // Two-flop synchronisers for the pad levels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
        end else begin
            r_scl_s1 <= scl_in;
            r_scl_s2 <= r_scl_s1;
            r_sda_s1 <= sda_in;
            r_sda_s2 <= r_sda_s1;
        end
    end

    // Register file, phase/quarter sequencer and registered pad outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase   <= StIdle;
            r_q       <= 2'd0;
            r_cnt     <= 16'd0;
            r_bit     <= 4'd0;
            r_shift   <= 8'd0;
            r_tx      <= 8'd0;
            r_rx      <= 8'd0;
            r_div     <= DEFAULT_DIV;
            r_ien     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rx_nack <= 1'b0;
            r_op_wr   <= 1'b0;
            r_op_rd   <= 1'b0;
            r_op_stop <= 1'b0;
            r_op_nack <= 1'b0;
            r_scl_oe  <= 1'b0;
            r_sda_oe  <= 1'b0;
        end else begin
            if (w_wr && address == 2'd0) r_tx <= writedata[7:0];
            if (w_wr && address == 2'd3 && !r_busy) r_div <= writedata[15:0];
            if (w_cmd_wr) r_ien <= writedata[8];
            if (w_go) begin
                r_busy    <= 1'b1;
                r_done    <= 1'b0;
                r_op_wr   <= w_wr_n;
                r_op_rd   <= w_rd_n;
                r_op_stop <= writedata[3];
                r_op_nack <= w_nack_n;
            end
            r_shift <= w_shift_nxt;
            if (w_step) begin
                r_scl_oe <= w_scl_nxt;
                r_sda_oe <= w_sda_nxt;
                r_q      <= w_ent_q;
                r_cnt    <= r_div;
            end else if (r_busy && !w_hold && r_cnt != 16'd0) begin
                r_cnt <= r_cnt - 16'd1;
            end
            if (w_enter) begin
                r_phase <= w_ent_phase;
                r_bit   <= w_ent_bit;
            end
            if (w_finish) begin
                r_phase <= StIdle;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
            end
            // SDA is sampled on the last clk of Q2 while SCL is high.
            if (w_qend && r_phase == StBit && r_q == 2'd2) begin
                if (r_bit == 4'd8) begin
                    if (r_op_wr) r_rx_nack <= r_sda_s2;
                end else if (r_op_rd) begin
                    r_rx <= {r_rx[6:0], r_sda_s2};
                end
            end
        end
    end

    // Register read mux.
    always_comb begin
        readdata = 32'd0;
        case (address)
            2'd0:    readdata = {24'd0, r_rx};
            2'd2:    readdata = {29'd0, r_rx_nack, r_done, r_busy};
            2'd3:    readdata = {16'd0, r_div};
            default: readdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_de0_nano_i2c_master_ctrl.sv
// Directed bench for the I2C master with an open-drain bus and a simple slave model.
module tb_de0_nano_i2c_master_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd2;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        scl_oe, sda_oe, irq;
    wire         scl_pad;
    wire         sda_pad;

    logic        scl_hold = 1'b0;
    logic        sda_low = 1'b0;
    int          mode = 0;          // 0 = slave receives, 1 = slave transmits rd_byte
    logic        ack_low = 1'b1;
    logic [7:0]  rd_byte = 8'd0;
    int          bit_cnt = 0;
    logic        rec [0:15];
    int          rec_n = 0;
    logic        start_seen = 1'b0;
    logic        stop_seen = 1'b0;
    logic        stretch_en = 1'b0;
    logic        stretched = 1'b0;

    int          n_cmp = 0;
    int          n_bad = 0;

    assign scl_pad = ~(scl_oe | scl_hold);
    assign sda_pad = ~(sda_oe | sda_low);

    always #5 clk = ~clk;

    de0_nano_i2c_master_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .scl_oe     (scl_oe),
        .sda_oe     (sda_oe),
        .scl_in     (scl_pad),
        .sda_in     (sda_pad),
        .irq        (irq)
    );

    // Slave: record SDA on each SCL rise and count bits in the byte.
    always @(posedge scl_pad) begin
        if (rec_n < 16) rec[rec_n] = sda_pad;
        rec_n = rec_n + 1;
        bit_cnt = (bit_cnt == 8) ? 0 : bit_cnt + 1;
    end

    // Slave: change SDA while SCL is low; optionally start a stretch before bit 3.
    always @(negedge scl_pad) begin
        if (stretch_en && bit_cnt == 4) begin
            scl_hold   = 1'b1;
            stretch_en = 1'b0;
            stretched  = 1'b1;
        end
        if (bit_cnt == 8) sda_low = (mode == 0) && ack_low;
        else if (mode == 1) sda_low = ~rd_byte[3'(7 - bit_cnt)];
        else sda_low = 1'b0;
    end

    // Slave: keep SCL low for 50 clk after the master releases it.
    always @(negedge scl_oe) begin
        if (scl_hold) begin
            repeat (50) @(posedge clk);
            @(negedge clk);
            scl_hold = 1'b0;
        end
    end

    always @(negedge sda_pad) if (scl_pad) begin
        start_seen = 1'b1;
        bit_cnt = 0;
    end

    always @(posedge sda_pad) if (scl_pad) stop_seen = 1'b1;

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; address = 2'd2;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1 d = readdata;
        address = 2'd2;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        address = 2'd2;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (readdata[1] === 1'b1) break;
            if (cyc >= 5000) break;
        end
        n_cmp++;
        if (readdata[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL done_timeout: got done=%b after %0d clk, need 1", readdata[1], cyc);
        end
    endtask

    function automatic logic [7:0] rec_byte();
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7 - i] = rec[i];
        return b;
    endfunction

    task automatic clear_slave();
        rec_n = 0; start_seen = 1'b0; stop_seen = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        rd(2'd2, d);
        n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL reset_status: got %h need 0", d); end
        rd(2'd3, d);
        n_cmp++; if (d !== 32'd124) begin n_bad++; $display("FAIL reset_div: got %0d need 124", d); end
        rd(2'd0, d);
        n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL reset_rx: got %h need 0", d); end
        n_cmp++; if ({scl_oe, sda_oe, irq} !== 3'b000) begin
            n_bad++; $display("FAIL reset_pads: got scl/sda/irq=%b need 000", {scl_oe, sda_oe, irq});
        end
    endtask

    task automatic test_write_ack_stop();
        int cyc;
        logic [31:0] d;
        mode = 0; ack_low = 1'b1; clear_slave();
        bus_write(2'd3, 32'd3);
        bus_write(2'd0, 32'hA5);
        bus_write(2'd1, 32'h0B);
        wait_done(cyc);
        n_cmp++; if (cyc != 176) begin n_bad++; $display("FAIL wr_latency: got %0d need 176", cyc); end
        n_cmp++; if (rec_byte() !== 8'hA5) begin n_bad++; $display("FAIL wr_sda_bits: got %h need a5", rec_byte()); end
        n_cmp++; if (rec[8] !== 1'b0) begin n_bad++; $display("FAIL wr_ack_bit: got %b need 0", rec[8]); end
        rd(2'd2, d);
        n_cmp++; if (d !== 32'h2) begin n_bad++; $display("FAIL wr_status: got %h need 2", d); end
        n_cmp++; if ({start_seen, stop_seen} !== 2'b11) begin
            n_bad++; $display("FAIL wr_start_stop: got %b need 11", {start_seen, stop_seen});
        end
        n_cmp++; if ({scl_oe, sda_oe, irq} !== 3'b000) begin
            n_bad++; $display("FAIL wr_bus_released: got %b need 000", {scl_oe, sda_oe, irq});
        end
    endtask

    task automatic test_write_nack_hold();
        int cyc;
        logic [31:0] d;
        mode = 0; ack_low = 1'b0; clear_slave();
        bus_write(2'd0, 32'h3C);
        bus_write(2'd1, 32'h103);
        wait_done(cyc);
        n_cmp++; if (cyc != 160) begin n_bad++; $display("FAIL nack_latency: got %0d need 160", cyc); end
        n_cmp++; if (rec_byte() !== 8'h3C) begin n_bad++; $display("FAIL nack_sda_bits: got %h need 3c", rec_byte()); end
        rd(2'd2, d);
        n_cmp++; if (d !== 32'h6) begin n_bad++; $display("FAIL nack_status: got %h need 6", d); end
        n_cmp++; if ({scl_oe, irq, stop_seen} !== 3'b110) begin
            n_bad++; $display("FAIL nack_held_irq: got scl_oe/irq/stop=%b need 110", {scl_oe, irq, stop_seen});
        end
        ack_low = 1'b1;
    endtask

    task automatic test_read_nack_stop();
        int cyc;
        logic [31:0] d;
        mode = 1; rd_byte = 8'h96; sda_low = ~rd_byte[7]; clear_slave();
        bus_write(2'd1, 32'h1C);
        wait_done(cyc);
        n_cmp++; if (cyc != 160) begin n_bad++; $display("FAIL rd_latency: got %0d need 160", cyc); end
        rd(2'd0, d);
        n_cmp++; if (d !== 32'h96) begin n_bad++; $display("FAIL rd_data: got %h need 96", d); end
        n_cmp++; if (rec[8] !== 1'b1) begin n_bad++; $display("FAIL rd_ack_slot_sda: got %b need 1", rec[8]); end
        n_cmp++; if ({stop_seen, scl_oe, sda_oe, irq} !== 4'b1000) begin
            n_bad++; $display("FAIL rd_stop: got stop/scl/sda/irq=%b need 1000",
                              {stop_seen, scl_oe, sda_oe, irq});
        end
        mode = 0; sda_low = 1'b0;
    endtask

    task automatic test_clock_stretch();
        int cyc;
        logic [31:0] d;
        clear_slave(); stretched = 1'b0; stretch_en = 1'b1;
        bus_write(2'd3, 32'd1);
        bus_write(2'd0, 32'h5A);
        bus_write(2'd1, 32'h0B);
        wait_done(cyc);
        // 8 + 72 + 8 clk at DIV=1, plus the 50 clk stretch.
        n_cmp++; if (cyc != 138) begin n_bad++; $display("FAIL stretch_latency: got %0d need 138", cyc); end
        n_cmp++; if ({stretched, rec[8]} !== 2'b10) begin
            n_bad++; $display("FAIL stretch_ack: got stretched/ack=%b need 10", {stretched, rec[8]});
        end
        n_cmp++; if (rec_byte() !== 8'h5A) begin n_bad++; $display("FAIL stretch_data: got %h need 5a", rec_byte()); end
        rd(2'd2, d);
        n_cmp++; if (d !== 32'h2) begin n_bad++; $display("FAIL stretch_status: got %h need 2", d); end
    endtask

    task automatic test_busy_and_reset();
        int cyc;
        logic [31:0] d;
        clear_slave();
        bus_write(2'd0, 32'hC3);
        bus_write(2'd1, 32'h03);
        bus_write(2'd1, 32'h108);
        bus_write(2'd3, 32'd7);
        rd(2'd2, d);
        n_cmp++; if (d[0] !== 1'b1) begin n_bad++; $display("FAIL busy_flag: got %b need 1", d[0]); end
        wait_done(cyc);
        n_cmp++; if (cyc + 4 != 80) begin n_bad++; $display("FAIL busy_latency: got %0d need 80", cyc + 4); end
        rd(2'd3, d);
        n_cmp++; if (d !== 32'd1) begin n_bad++; $display("FAIL busy_div_kept: got %0d need 1", d); end
        n_cmp++; if ({scl_oe, irq, stop_seen} !== 3'b100) begin
            n_bad++; $display("FAIL busy_cmd_ignored: got scl/irq/stop=%b need 100", {scl_oe, irq, stop_seen});
        end
        bus_write(2'd1, 32'h0B);
        repeat (20) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if ({scl_oe, sda_oe, irq} !== 3'b000) begin
            n_bad++; $display("FAIL reset_mid_pads: got %b need 000", {scl_oe, sda_oe, irq});
        end
        rd(2'd2, d);
        n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL reset_mid_status: got %h need 0", d); end
        rd(2'd3, d);
        n_cmp++; if (d !== 32'd124) begin n_bad++; $display("FAIL reset_mid_div: got %0d need 124", d); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_write_ack_stop();
        test_write_nack_hold();
        test_read_nack_stop();
        test_clock_stretch();
        test_busy_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
